// File: rtl/mem_instr_mp_if.sv
// Bus bundle for mem_instr_mp: programming write port plus NUM_PORTS
// independent read ports. The loader/fetch side uses master; the memory uses slave.
interface mem_instr_mp_if #(
    parameter int DATA_W    = 10,
    parameter int ADDR_W    = 5,
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]        rd_en;
    logic [NUM_PORTS*ADDR_W-1:0] rd_addr;
    logic [NUM_PORTS*DATA_W-1:0] instr_out;
    logic [NUM_PORTS-1:0]        instr_valid;
    logic                        wr_en;
    logic [ADDR_W-1:0]           wr_addr;
    logic [DATA_W-1:0]           wr_data;
    logic                        wr_ack;
    logic                        busy;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  instr_out, instr_valid, wr_ack, busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output instr_out, instr_valid, wr_ack, busy
    );
endinterface

// File: rtl/mem_instr_mp.sv
// Multi-port instruction memory: one write port, NUM_PORTS registered read
// ports, and a sequential one-entry-per-clock initialisation pass after clear.
module mem_instr_mp #(
    parameter int DATA_W     = 10,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 32,
    parameter int NUM_PORTS  = 2,
    parameter int INIT_COUNT = 10
) (
    input  logic          clock,
    input  logic          clear,
    mem_instr_mp_if.slave bus
);
    typedef enum logic {INIT, READY} state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   INIT_L  = (ADDR_W + 1)'(INIT_COUNT);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              wr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Select the single memory write source: init pattern or host write.
    always_comb begin
        wr_ok     = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_L);
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        if (state == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = ({1'b0, cnt} < INIT_L) ? DATA_W'(cnt) : '0;
        end else begin
            mem_we = wr_ok;
        end
    end

    // Storage array; kept out of the reset domain so it maps onto RAM.
    // Reads below sample the pre-edge contents, giving read-first collisions.
    always_ff @(posedge clock) begin
        if (mem_we && !clear)
            mem[mem_waddr] <= mem_wdata;
    end

    // Control FSM with registered busy/ack and per-port read registers.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state           <= INIT;
            cnt             <= '0;
            bus.busy        <= 1'b1;
            bus.wr_ack      <= 1'b0;
            bus.instr_valid <= '0;
            bus.instr_out   <= '0;
        end else begin
            bus.wr_ack      <= 1'b0;
            bus.instr_valid <= '0;
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= READY;
                        bus.busy <= 1'b0;
                    end
                end
                READY: begin
                    bus.wr_ack <= wr_ok;
                    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                        if (bus.rd_en[p]) begin
                            bus.instr_valid[p] <= 1'b1;
                            if ({1'b0, bus.rd_addr[p*ADDR_W +: ADDR_W]} < DEPTH_L)
                                bus.instr_out[p*DATA_W +: DATA_W] <= mem[bus.rd_addr[p*ADDR_W +: ADDR_W]];
                            else
                                bus.instr_out[p*DATA_W +: DATA_W] <= '0;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_instr_mp.sv
// Testbench for mem_instr_mp: behavioural model compared every cycle on the
// default-parameter instance, directed literal checks on both instances.
module tb_mem_instr_mp;
    localparam int DW = 10;
    localparam int AW = 5;
    localparam int D  = 32;
    localparam int NP = 2;
    localparam int IC = 10;
    localparam int D2 = 20;

    logic clock = 1'b0;
    logic clear = 1'b0;
    always #5 clock = ~clock;

    mem_instr_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_PORTS(NP)) bus ();
    mem_instr_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_PORTS(NP)) bus2 ();

    mem_instr_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .NUM_PORTS(NP), .INIT_COUNT(IC))
        dut (.clock(clock), .clear(clear), .bus(bus));
    mem_instr_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D2), .NUM_PORTS(NP), .INIT_COUNT(IC))
        dut2 (.clock(clock), .clear(clear), .bus(bus2));

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the default instance ----------------
    int unsigned   mmem [D];
    int unsigned   left;
    logic [DW-1:0] e_out [NP];
    logic          e_valid [NP];
    logic          e_ack;
    logic          e_busy;

    // Model: clear reloads the pattern and starts a DEPTH-edge busy window;
    // afterwards reads see the old contents and writes land afterwards.
    always @(posedge clock or posedge clear) begin
        if (clear) begin
            left   = D;
            e_busy = 1'b1;
            e_ack  = 1'b0;
            for (int p = 0; p < NP; p++) begin
                e_out[p]   = '0;
                e_valid[p] = 1'b0;
            end
            for (int i = 0; i < D; i++) mmem[i] = (i < IC) ? i : 0;
        end else if (left > 0) begin
            left   = left - 1;
            e_busy = (left != 0);
            e_ack  = 1'b0;
            for (int p = 0; p < NP; p++) e_valid[p] = 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                int unsigned a;
                a = bus.rd_addr[p*AW +: AW];
                e_valid[p] = bus.rd_en[p];
                if (bus.rd_en[p]) e_out[p] = (a < D) ? DW'(mmem[a]) : '0;
            end
            e_ack = 1'b0;
            if (bus.wr_en && (int'(bus.wr_addr) < D)) begin
                mmem[bus.wr_addr] = bus.wr_data;
                e_ack = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clock) begin
        if (model_on) begin
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("wr_ack", 32'(bus.wr_ack), 32'(e_ack));
            for (int p = 0; p < NP; p++) begin
                chk("instr_valid", 32'(bus.instr_valid[p]), 32'(e_valid[p]));
                chk("instr_out", 32'(bus.instr_out[p*DW +: DW]), 32'(e_out[p]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        bus.rd_en = '0; bus.rd_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus2.rd_en = '0; bus2.rd_addr = '0; bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
    endtask

    task automatic check_async_clear();
        #1;
        chk("async_busy", 32'(bus.busy), 32'd1);
        chk("async_ack", 32'(bus.wr_ack), 32'd0);
        chk("async_valid", 32'(bus.instr_valid), 32'd0);
        chk("async_out", 32'(bus.instr_out), 32'd0);
    endtask

    // Release clear and verify busy spans exactly D edges (D2 for dut2).
    task automatic release_and_count();
        clear = 1'b0;
        for (int k = 1; k <= D; k++) begin
            nxt();
            chk("busy_window", 32'(bus.busy), (k < D) ? 32'd1 : 32'd0);
            if (k == D2 - 1 || k == D2)
                chk("busy_window2", 32'(bus2.busy), (k < D2) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic read0(input int a);
        bus.rd_en = 2'b01;
        bus.rd_addr[0 +: AW] = AW'(a);
        nxt();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        idle();
        #2;
        clear = 1'b1;
        check_async_clear();
        model_on = 1'b1;
        nxt();

        // Requests during INIT must be ignored.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 10'h155;
        bus.rd_en = 2'b11; bus.rd_addr = {5'd4, 5'd2};
        release_and_count();
        idle();

        // Init pattern on port 0, back-to-back reads.
        for (int a = 0; a < D; a++) begin
            read0(a);
            chk("init_pattern", 32'(bus.instr_out[0 +: DW]), (a < IC) ? a : 0);
            chk("init_valid", 32'(bus.instr_valid[0]), 32'd1);
            chk("model_pin", 32'(e_out[0]), (a < IC) ? a : 0);
        end

        // Parallel reads.
        bus.rd_en = 2'b11; bus.rd_addr = {5'd3, 5'd3};
        nxt();
        chk("par_out", 32'(bus.instr_out), {12'd0, 10'd3, 10'd3});
        chk("par_valid", 32'(bus.instr_valid), 32'd3);
        bus.rd_addr = {5'd9, 5'd7};
        nxt();
        chk("par_out2", 32'(bus.instr_out), {12'd0, 10'd9, 10'd7});
        chk("par_valid2", 32'(bus.instr_valid), 32'd3);
        idle();

        // Read-first collision.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 10'h3FF;
        read0(5);
        chk("coll_old", 32'(bus.instr_out[0 +: DW]), 32'd5);
        chk("coll_ack", 32'(bus.wr_ack), 32'd1);
        bus.wr_en = 1'b0;
        read0(5);
        chk("coll_new", 32'(bus.instr_out[0 +: DW]), 32'h3FF);
        chk("coll_ack_end", 32'(bus.wr_ack), 32'd0);
        idle();

        // Out-of-range on the DEPTH=20 instance.
        bus2.wr_en = 1'b1; bus2.wr_addr = 5'd25; bus2.wr_data = 10'h2AB;
        nxt();
        chk("oor_ack", 32'(bus2.wr_ack), 32'd0);
        bus2.wr_en = 1'b0;
        bus2.rd_en = 2'b01; bus2.rd_addr[0 +: AW] = 5'd25;
        nxt();
        chk("oor_data", 32'(bus2.instr_out[0 +: DW]), 32'd0);
        chk("oor_valid", 32'(bus2.instr_valid[0]), 32'd1);
        for (int a = 0; a < D2; a++) begin
            bus2.rd_addr[0 +: AW] = AW'(a);
            nxt();
            chk("oor_others", 32'(bus2.instr_out[0 +: DW]), (a < IC) ? a : 0);
        end
        idle();

        // Clear in READY discards host writes.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = 10'h0AA;
        nxt();
        chk("run_ack", 32'(bus.wr_ack), 32'd1);
        idle();
        clear = 1'b1;
        check_async_clear();
        nxt();
        release_and_count();
        read0(1);
        chk("after_clear", 32'(bus.instr_out[0 +: DW]), 32'd1);
        idle();

        // Clear mid-init at count 17 restarts the full pass.
        clear = 1'b1;
        nxt();
        clear = 1'b0;
        repeat (17) nxt();
        chk("mid_init_busy", 32'(bus.busy), 32'd1);
        clear = 1'b1;
        nxt();
        release_and_count();

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.rd_en   = NP'($urandom_range(0, 3));
            bus.rd_addr = (NP*AW)'($urandom);
            bus.wr_en   = ($urandom_range(0, 2) == 0);
            bus.wr_addr = AW'($urandom_range(0, 7));
            bus.wr_data = DW'($urandom);
            if (bus.rd_en[0]) bus.rd_addr[0 +: AW] = AW'($urandom_range(0, 7));
            clear = ($urandom_range(0, 399) == 0);
            nxt();
        end
        clear = 1'b0;
        idle();
        repeat (D + 2) nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
